mem_stage_hs: RTL and testbench

Parametrised memory-access stage with a MEM/WB pipeline register for the pipelined ARM core. It replaces the fixed single-cycle memory stage with a request/acknowledge handshake that stalls the pipeline for variable-latency memory and aborts on timeout. It also adds byte and halfword stores and loads with lane steering and sign or zero extension. A generalised store-data increment replaces the old PlusOne. It sits between EX/MEM and the writeback stage, in front of the data memory and framebuffer bus.

---
 rtl/mem_stage_hs.sv | 104 ++++++++++
 tb/tb_mem_stage_hs.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: memory-access stage with req/ack handshake, timeout abort,
// sub-word lane steering and the MEM/WB pipeline register.
module mem_stage_hs #(
  parameter int ADDR_W   = 32,
  parameter int REG_W    = 4,
  parameter int INC_W    = 1,
  parameter int WAIT_MAX = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              validM,
  input  logic              flushM,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  input  logic [INC_W-1:0]  IncM,
  input  logic [REG_W-1:0]  WA3M,
  input  logic              MemToRegM,
  input  logic              MemWriteM,
  input  logic              RegWriteM,
  input  logic              PCSrcM,
  input  logic [1:0]        SizeM,
  input  logic              SignedM,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memWData,
  output logic [3:0]        memBe,
  input  logic              memAck,
  input  logic [31:0]       memRData,
  output logic              stallM,
  output logic              validW,
  output logic              MemToRegW,
  output logic              RegWriteW,
  output logic              PCSrcW,
  output logic              errorW,
  output logic [31:0]       ReadDataW,
  output logic [31:0]       ALUResultW,
  output logic [REG_W-1:0]  WA3W
);
  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             w_half, w_byte, w_is_mem, w_mis, w_v, w_ack, w_timeout, w_err;
  logic [31:0]      w_sd, w_ext;
  logic [15:0]      w_h;
  logic [7:0]       w_b;
  assign w_half    = SizeM == 2'b01;
  assign w_byte    = SizeM == 2'b10;
  assign w_is_mem  = MemToRegM | MemWriteM;
  assign w_mis     = w_half ? ALUResultM[0] : !w_byte & (ALUResultM[1:0] != 2'b00);
  assign w_v       = validM & !flushM;
  assign memReq    = reset & w_v & w_is_mem & !w_mis;
  // an ack without a live request is ignored everywhere
  assign w_ack     = memReq & memAck;
  assign w_timeout = memReq & (r_state == S_WAIT) & (r_count == CNT_W'(WAIT_MAX - 1)) & !memAck;
  assign stallM    = memReq & !memAck & !w_timeout;
  assign w_err     = w_v & (w_timeout | (w_is_mem & w_mis));
  assign memWe     = MemWriteM;
  assign memAddr   = ALUResultM[ADDR_W-1:0];
  assign memBe     = w_byte ? 4'b0001 << ALUResultM[1:0] :
                     w_half ? (ALUResultM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_sd      = WriteDataM + 32'(IncM);
  assign memWData  = w_byte ? {4{w_sd[7:0]}} : w_half ? {2{w_sd[15:0]}} : w_sd;
  assign w_h       = ALUResultM[1] ? memRData[31:16] : memRData[15:0];
  assign w_b       = memRData[{ALUResultM[1:0], 3'b000} +: 8];
  assign w_ext     = w_byte ? {{24{SignedM & w_b[7]}}, w_b} :
                     w_half ? {{16{SignedM & w_h[15]}}, w_h} : memRData;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else if (r_state == S_IDLE) begin
      if (memReq & !memAck) begin
        r_state <= S_WAIT;
        r_count <= CNT_W'(1);
      end
    end else if (!memReq | memAck | w_timeout) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else
      r_count <= r_count + CNT_W'(1);
  // a stalled cycle retires a bubble into W
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      validW     <= 1'b0;
      errorW     <= 1'b0;
      RegWriteW  <= 1'b0;
      MemToRegW  <= 1'b0;
      PCSrcW     <= 1'b0;
      ReadDataW  <= '0;
      ALUResultW <= '0;
      WA3W       <= '0;
    end else begin
      validW     <= !stallM & w_v;
      errorW     <= !stallM & w_err;
      RegWriteW  <= !stallM & w_v & RegWriteM & !w_err;
      MemToRegW  <= !stallM & w_v & MemToRegM & !w_err;
      PCSrcW     <= !stallM & w_v & PCSrcM;
      ReadDataW  <= w_ack ? w_ext : '0;
      ALUResultW <= ALUResultM;
      WA3W       <= WA3M;
    end
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: directed vector table, reset sequences and randomized
// transactions checked against a transaction-level reference model.
module tb_mem_stage_hs;
  localparam int WM = 4;
  logic        clock = 0, reset = 1;
  logic        validM = 0, flushM = 0, MemToRegM = 0, MemWriteM = 0, RegWriteM = 0, PCSrcM = 0;
  logic        SignedM = 0, memAck = 0;
  logic [31:0] ALUResultM = 0, WriteDataM = 0, memRData = 0;
  logic [0:0]  IncM = 0;
  logic [3:0]  WA3M = 0;
  logic [1:0]  SizeM = 0;
  logic        memReq, memWe, stallM, validW, MemToRegW, RegWriteW, PCSrcW, errorW;
  logic [31:0] memAddr, memWData, ReadDataW, ALUResultW;
  logic [3:0]  memBe, WA3W;
  int n_cmp = 0, n_bad = 0;

  mem_stage_hs #(.ADDR_W(32), .REG_W(4), .INC_W(1), .WAIT_MAX(WM)) dut (
    .clock(clock), .reset(reset), .validM(validM), .flushM(flushM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .IncM(IncM), .WA3M(WA3M),
    .MemToRegM(MemToRegM), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .PCSrcM(PCSrcM),
    .SizeM(SizeM), .SignedM(SignedM), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memWData(memWData), .memBe(memBe), .memAck(memAck), .memRData(memRData),
    .stallM(stallM), .validW(validW), .MemToRegW(MemToRegW), .RegWriteW(RegWriteW),
    .PCSrcW(PCSrcW), .errorW(errorW), .ReadDataW(ReadDataW), .ALUResultW(ALUResultW),
    .WA3W(WA3W));

  always #5 clock = ~clock;

  typedef struct {
    bit        valid, flush, mtr, mw, rw, pc, sgn, inc;
    bit [1:0]  size;
    bit [31:0] addr, wdata, rdata;
    bit [3:0]  wa3;
    int        ack_at;
    bit        e_req, e_err, e_v, e_rw, e_mtr, e_pc;
    bit [3:0]  e_be;
    bit [31:0] e_wd, e_rd;
    int        e_stalls;
  } txn_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic txn_t mk(bit [31:0] addr, bit [1:0] size, bit sgn, bit mtr, bit mw, bit rw,
                              bit [31:0] wdata, bit inc, bit [31:0] rdata, int ack_at,
                              bit e_req, bit [3:0] e_be, bit [31:0] e_wd, int e_stalls,
                              bit e_err, bit [31:0] e_rd, bit e_rw);
    txn_t t;
    t.valid = 1; t.flush = 0; t.addr = addr; t.size = size; t.sgn = sgn;
    t.mtr = mtr; t.mw = mw; t.rw = rw; t.pc = 0; t.wdata = wdata; t.inc = inc;
    t.rdata = rdata; t.ack_at = ack_at; t.wa3 = addr[5:2];
    t.e_req = e_req; t.e_be = e_be; t.e_wd = e_wd; t.e_stalls = e_stalls;
    t.e_err = e_err; t.e_rd = e_rd; t.e_rw = e_rw;
    t.e_v = 1; t.e_mtr = mtr & !e_err; t.e_pc = 0;
    return t;
  endfunction

  // transaction-level model: access width, alignment, replication and extension by arithmetic
  function automatic txn_t model(input txn_t t);
    int bytes = t.size == 2'd1 ? 2 : t.size == 2'd2 ? 1 : 4;
    int off = int'(t.addr % 4);
    bit [31:0] mask = bytes == 4 ? 32'hFFFF_FFFF : (32'h1 << (8 * bytes)) - 1;
    bit [31:0] sd = t.wdata + 32'(t.inc);
    bit ismem = t.mtr | t.mw;
    bit mis = (off % bytes) != 0;
    bit timed;
    t.e_v = t.valid & !t.flush;
    t.e_req = t.e_v & ismem & !mis;
    timed = t.e_req & (t.ack_at == 0 || t.ack_at > WM);
    t.e_stalls = !t.e_req ? 0 : timed ? WM - 1 : t.ack_at - 1;
    t.e_err = t.e_v & ((ismem & mis) | timed);
    t.e_be = 4'(((1 << bytes) - 1) << (off - off % bytes));
    t.e_wd = 0;
    for (int i = 0; i < 4; i += bytes) t.e_wd |= (sd & mask) << (8 * i);
    t.e_rd = 0;
    if (t.e_req & !timed) begin
      t.e_rd = (t.rdata >> (8 * off)) & mask;
      if (t.sgn && bytes < 4 && t.e_rd[8 * bytes - 1]) t.e_rd |= ~mask;
    end
    t.e_rw = t.e_v & t.rw & !t.e_err;
    t.e_mtr = t.e_v & t.mtr & !t.e_err;
    t.e_pc = t.e_v & t.pc;
    return t;
  endfunction

  // entered and left at posedge+1
  task automatic run_txn(input txn_t t, input string nm);
    validM = t.valid; flushM = t.flush; ALUResultM = t.addr; WriteDataM = t.wdata;
    IncM = t.inc; WA3M = t.wa3; MemToRegM = t.mtr; MemWriteM = t.mw; RegWriteM = t.rw;
    PCSrcM = t.pc; SizeM = t.size; SignedM = t.sgn; memRData = t.rdata;
    for (int c = 1; c <= t.e_stalls + 1; c++) begin
      memAck = (c == t.ack_at);
      #4;
      chk({nm, ".memReq"}, memReq, t.e_req);
      chk({nm, ".stallM"}, stallM, c <= t.e_stalls);
      if (c == 1) begin
        chk({nm, ".memBe"}, memBe, t.e_be);
        chk({nm, ".memWData"}, memWData, t.e_wd);
        chk({nm, ".memWe"}, memWe, t.mw);
        chk({nm, ".memAddr"}, memAddr, t.addr);
      end
      @(posedge clock); #1;
      if (c <= t.e_stalls) begin
        chk({nm, ".bubble_validW"}, validW, 0);
        chk({nm, ".bubble_errorW"}, errorW, 0);
        chk({nm, ".bubble_RegWriteW"}, RegWriteW, 0);
      end else begin
        chk({nm, ".validW"}, validW, t.e_v);
        chk({nm, ".errorW"}, errorW, t.e_err);
        chk({nm, ".RegWriteW"}, RegWriteW, t.e_rw);
        chk({nm, ".MemToRegW"}, MemToRegW, t.e_mtr);
        chk({nm, ".PCSrcW"}, PCSrcW, t.e_pc);
        chk({nm, ".ReadDataW"}, ReadDataW, t.e_rd);
        chk({nm, ".ALUResultW"}, ALUResultW, t.addr);
        chk({nm, ".WA3W"}, WA3W, t.wa3);
      end
    end
    memAck = 0;
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, ".memReq"}, memReq, 0);
    chk({nm, ".stallM"}, stallM, 0);
    chk({nm, ".validW"}, validW, 0);
    chk({nm, ".errorW"}, errorW, 0);
    chk({nm, ".RegWriteW"}, RegWriteW, 0);
    chk({nm, ".MemToRegW"}, MemToRegW, 0);
    chk({nm, ".ReadDataW"}, ReadDataW, 0);
    chk({nm, ".ALUResultW"}, ALUResultW, 0);
    chk({nm, ".WA3W"}, WA3W, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t vecs[$];
    txn_t t;
    //      addr        sz sg mtr mw rw wdata          inc rdata          ack req be     wdata          st err rd             rw
    vecs.push_back(mk(32'h100, 0, 0, 0, 1, 0, 32'h12345678, 1, 32'h0,        1, 1, 4'hF, 32'h12345679, 0, 0, 32'h0,        0));
    vecs.push_back(mk(32'h103, 2, 1, 1, 0, 1, 32'h0,        0, 32'h80FF0000, 3, 1, 4'h8, 32'h0,        2, 0, 32'hFFFFFF80, 1));
    vecs.push_back(mk(32'h202, 1, 0, 1, 0, 1, 32'h0,        0, 32'hBEEF1234, 1, 1, 4'hC, 32'h0,        0, 0, 32'h0000BEEF, 1));
    vecs.push_back(mk(32'h300, 0, 0, 1, 0, 1, 32'h11111111, 0, 32'h55555555, 0, 1, 4'hF, 32'h11111111, 3, 1, 32'h0,        0));
    vecs.push_back(mk(32'h304, 0, 0, 1, 0, 1, 32'h0,        0, 32'hCAFEF00D, 1, 1, 4'hF, 32'h0,        0, 0, 32'hCAFEF00D, 1));
    vecs.push_back(mk(32'h101, 0, 0, 1, 0, 1, 32'h0,        0, 32'h12345678, 1, 0, 4'hF, 32'h0,        0, 1, 32'h0,        0));
    vecs.push_back(mk(32'h206, 1, 0, 0, 1, 0, 32'h0000ABCD, 1, 32'h0,        1, 1, 4'hC, 32'hABCEABCE, 0, 0, 32'h0,        0));
    vecs.push_back(mk(32'h001, 2, 0, 0, 1, 0, 32'h000000FF, 1, 32'h0,        1, 1, 4'h2, 32'h0,        0, 0, 32'h0,        0));
    vecs.push_back(mk(32'h008, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 32'h0,        2, 1, 4'hF, 32'h0,        1, 0, 32'h0,        0));
    vecs.push_back(mk(32'h310, 0, 0, 1, 0, 1, 32'h0,        0, 32'hA5A5A5A5, 4, 1, 4'hF, 32'h0,        3, 0, 32'hA5A5A5A5, 1));
    vecs.push_back(mk(32'h0ABCDEF1, 0, 0, 0, 0, 1, 32'h1,   0, 32'hFFFFFFFF, 1, 0, 4'hF, 32'h1,        0, 0, 32'h0,        1));
    vecs.push_back(mk(32'h200, 1, 1, 1, 0, 1, 32'h0,        0, 32'h00008001, 2, 1, 4'h3, 32'h0,        1, 0, 32'hFFFF8001, 1));
    vecs.push_back(mk(32'h203, 1, 0, 0, 1, 0, 32'h1234,     0, 32'h0,        1, 0, 4'hC, 32'h12341234, 0, 1, 32'h0,        0));
    vecs.push_back(mk(32'h102, 2, 0, 1, 0, 1, 32'h0,        0, 32'h80FF0000, 1, 1, 4'h4, 32'h0,        0, 0, 32'h000000FF, 1));
    vecs.push_back(mk(32'h104, 3, 1, 1, 0, 1, 32'h0,        0, 32'h87654321, 1, 1, 4'hF, 32'h0,        0, 0, 32'h87654321, 1));
    t = mk(32'h400, 0, 0, 1, 0, 1, 32'h0, 0, 32'h1, 1, 0, 4'hF, 32'h0, 0, 0, 32'h0, 0);
    t.flush = 1; t.e_v = 0; t.e_mtr = 0;
    vecs.push_back(t);

    #1 reset = 0;
    validM = 1; MemToRegM = 1; RegWriteM = 1; ALUResultM = 32'h500; WA3M = 4'h3;
    #1 chk_cleared("reset");
    @(posedge clock); #1 reset = 1;

    for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    validM = 1; flushM = 0; ALUResultM = 32'h400; SizeM = 0; MemToRegM = 1; MemWriteM = 0;
    RegWriteM = 1; PCSrcM = 0; WA3M = 4'h7; memAck = 0;
    @(posedge clock); #1;
    chk("rst_wait.stall1", stallM, 1);
    @(posedge clock); #1;
    chk("rst_wait.stall2", stallM, 1);
    #2 reset = 0;
    #1 chk_cleared("rst_wait");
    @(posedge clock); #1 reset = 1;
    run_txn(mk(32'h404, 0, 0, 1, 0, 1, 32'h0, 0, 32'h13572468, 3, 1, 4'hF, 32'h0, 2, 0, 32'h13572468, 1), "post_rst");

    for (int i = 0; i < 150; i++) begin
      int k = $urandom_range(0, 2);
      t.valid = $urandom_range(0, 9) != 0;
      t.flush = $urandom_range(0, 9) == 0;
      t.addr = $urandom;
      t.size = 2'($urandom_range(0, 3));
      t.sgn = 1'($urandom_range(0, 1));
      t.mtr = k == 0;
      t.mw = k == 1;
      t.rw = 1'($urandom_range(0, 1));
      t.pc = 1'($urandom_range(0, 1));
      t.wdata = $urandom;
      t.inc = 1'($urandom_range(0, 1));
      t.rdata = $urandom;
      t.wa3 = 4'($urandom_range(0, 15));
      t.ack_at = $urandom_range(0, WM + 1);
      run_txn(model(t), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
